// File: rtl/tan_series_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tan_series_engine
//
// Fixed-point tan(x) / tanh(x) evaluator. A truncated odd Taylor series
//     f(x) = x * (c0 + x^2*(c1 + x^2*(c2 + ...)))
// is evaluated with Horner's rule, one multiply per cycle, on a single
// shared multiplier. In tanh mode the odd-indexed coefficients change sign.
//
// Parameters
//   WIDTH  signed width of x and result
//   FRAC   fraction bits of x and result (FRAC >= 1)
//   TERMS  number of series terms, 1..8
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   request, sampled only while idle or done
//   mode    0 = tan, 1 = tanh, captured together with x on an accepted start
//   x       signed operand, FRAC fraction bits
//   busy    high while a computation is in progress
//   ready   one-cycle pulse when result/ovf have just been updated
//   result  saturated signed result, FRAC fraction bits
//   ovf     result was clamped to the symmetric output range
// -----------------------------------------------------------------------------
module tan_series_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14,
    parameter int TERMS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x,
    output logic                    busy,
    output logic                    ready,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    // Accumulator and product widths.
    localparam int AW = WIDTH + 4;
    localparam int PW = 2 * WIDTH + 4;
    // Coefficient index width: the ROM always has 8 slots.
    localparam int CW = 3;

    localparam logic [CW-1:0] TOP_IDX  = CW'(TERMS - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'((TERMS >= 2) ? (TERMS - 2) : 0);

    localparam logic signed [PW-1:0]    ROUND_HALF = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [WIDTH-1:0] MAX_VAL    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    SAT_HI     = {{(PW-WIDTH){1'b0}}, MAX_VAL};
    localparam logic signed [PW-1:0]    SAT_LO     = -SAT_HI;

    // round(a_k * 2^FRAC) for the tan series coefficients, in integer
    // arithmetic: floor((2*num*2^FRAC + den) / (2*den)).
    function automatic logic signed [AW-1:0] coef(input int k);
        longint num;
        longint den;
        longint scaled;
        case (k)
            0:       begin num = 1;      den = 1;         end
            1:       begin num = 1;      den = 3;         end
            2:       begin num = 2;      den = 15;        end
            3:       begin num = 17;     den = 315;       end
            4:       begin num = 62;     den = 2835;      end
            5:       begin num = 1382;   den = 155925;    end
            6:       begin num = 21844;  den = 6081075;   end
            7:       begin num = 929569; den = 638512875; end
            default: begin num = 0;      den = 1;         end
        endcase
        scaled = ((num << (FRAC + 1)) + den) / (2 * den);
        return AW'(scaled);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        HORNER,
        FINAL,
        DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic signed [WIDTH-1:0] x_reg;
    logic                    mode_reg;
    logic signed [AW-1:0]    x2_reg;
    logic signed [AW-1:0]    acc_reg;
    logic [CW-1:0]           cnt_reg;
    logic signed [WIDTH-1:0] result_reg;
    logic                    ovf_reg;

    // Constant coefficient ROMs; slots beyond TERMS are zero and never read.
    logic signed [AW-1:0] rom_tan  [8];
    logic signed [AW-1:0] rom_tanh [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_rom
        localparam logic signed [AW-1:0] C_VAL = (gi < TERMS) ? coef(gi) : '0;
        assign rom_tan[gi]  = C_VAL;
        // tanh differs from tan only by alternating signs of the terms.
        assign rom_tanh[gi] = (gi % 2 == 1) ? -C_VAL : C_VAL;
    end

    logic [CW-1:0]        coef_idx;
    logic signed [AW-1:0] coef_cur;

    // SQUARE seeds the accumulator with the highest-order coefficient.
    assign coef_idx = (state_reg == SQUARE) ? TOP_IDX : cnt_reg;
    assign coef_cur = mode_reg ? rom_tanh[coef_idx] : rom_tan[coef_idx];

    // Shared multiplier: x*x in SQUARE, acc*x2 in HORNER, acc*x in FINAL.
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] op_a;
    logic signed [AW-1:0] op_b;
    logic signed [PW-1:0] op_a_w;
    logic signed [PW-1:0] op_b_w;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;

    assign x_ext = {{(AW-WIDTH){x_reg[WIDTH-1]}}, x_reg};

    always_comb begin
        op_a = x_ext;
        op_b = x_ext;
        case (state_reg)
            HORNER: begin
                op_a = acc_reg;
                op_b = x2_reg;
            end
            FINAL: begin
                op_a = acc_reg;
                op_b = x_ext;
            end
            default: begin
                op_a = x_ext;
                op_b = x_ext;
            end
        endcase
    end

    assign op_a_w = {{(PW-AW){op_a[AW-1]}}, op_a};
    assign op_b_w = {{(PW-AW){op_b[AW-1]}}, op_b};
    assign prod   = op_a_w * op_b_w;
    // Round half up, then drop the fraction bits (floor for negatives).
    assign rnd    = (prod + ROUND_HALF) >>> FRAC;

    // Symmetric saturation so that negating the input negates the clamp.
    logic signed [WIDTH-1:0] sat_val;
    logic                    sat_ovf;

    always_comb begin
        sat_val = rnd[WIDTH-1:0];
        sat_ovf = 1'b0;
        if (rnd > SAT_HI) begin
            sat_val = MAX_VAL;
            sat_ovf = 1'b1;
        end else if (rnd < SAT_LO) begin
            sat_val = -MAX_VAL;
            sat_ovf = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SQUARE;
            end
            SQUARE: begin
                state_next = (TERMS == 1) ? FINAL : HORNER;
            end
            HORNER: begin
                if (cnt_reg == '0) state_next = FINAL;
            end
            FINAL: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = start ? SQUARE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg      <= '0;
            mode_reg   <= 1'b0;
            x2_reg     <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        x_reg    <= x;
                        mode_reg <= mode;
                    end
                end
                SQUARE: begin
                    x2_reg  <= rnd[AW-1:0];
                    acc_reg <= coef_cur;
                    cnt_reg <= CNT_INIT;
                end
                HORNER: begin
                    // Intermediate sums wrap at AW bits; only the final
                    // product is clamped.
                    acc_reg <= coef_cur + rnd[AW-1:0];
                    cnt_reg <= cnt_reg - CW'(1);
                end
                FINAL: begin
                    result_reg <= sat_val;
                    ovf_reg    <= sat_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_reg == SQUARE) || (state_reg == HORNER) || (state_reg == FINAL);
    assign ready  = (state_reg == DONE);
    assign result = result_reg;
    assign ovf    = ovf_reg;

endmodule

// File: tb/tb_tan_series_engine.sv
`timescale 1ns/1ps
module tb_tan_series_engine;

    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int TERMS = 4;
    localparam int AW    = WIDTH + 4;
    localparam longint MAXV = (longint'(1) << (WIDTH - 1)) - 1;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    mode;
    logic signed [WIDTH-1:0] x;
    logic                    busy;
    logic                    ready;
    logic signed [WIDTH-1:0] result;
    logic                    ovf;

    int tests_run;
    int tests_failed;
    longint last_res;

    tan_series_engine #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .TERMS (TERMS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .x      (x),
        .busy   (busy),
        .ready  (ready),
        .result (result),
        .ovf    (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // ---------------- reference model ----------------
    real num_tab [8] = '{1.0, 1.0, 2.0, 17.0, 62.0, 1382.0, 21844.0, 929569.0};
    real den_tab [8] = '{1.0, 3.0, 15.0, 315.0, 2835.0, 155925.0, 6081075.0, 638512875.0};

    function automatic longint coef_k(input int k, input bit m);
        longint c;
        c = longint'($rtoi(num_tab[k] / den_tab[k] * (2.0 ** FRAC) + 0.5));
        if (m && (k % 2 == 1)) c = -c;
        return c;
    endfunction

    function automatic longint rmul(input longint a, input longint b);
        longint half;
        half = longint'(1) << (FRAC - 1);
        return (a * b + half) >>> FRAC;
    endfunction

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64 - AW)) >>> (64 - AW);
    endfunction

    task automatic model(input longint xv, input bit m, output longint r, output bit o);
        longint x2;
        longint acc;
        longint p;
        x2  = rmul(xv, xv);
        acc = coef_k(TERMS - 1, m);
        for (int k = TERMS - 2; k >= 0; k--) acc = wrap_acc(coef_k(k, m) + rmul(acc, x2));
        p = rmul(acc, xv);
        if (p > MAXV) begin
            r = MAXV;  o = 1'b1;
        end else if (p < -MAXV) begin
            r = -MAXV; o = 1'b1;
        end else begin
            r = p;     o = 1'b0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // One full operation from an idle engine; inputs scrambled after acceptance.
    task automatic run_op(input string tag, input logic signed [WIDTH-1:0] xi, input logic mi);
        int n;
        int busy_cnt;
        longint er;
        bit eo;
        model(longint'(xi), mi, er, eo);
        start = 1'b1;
        x     = xi;
        mode  = mi;
        n = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                x     = WIDTH'($urandom);
                mode  = 1'($urandom);
            end
            if (busy) busy_cnt++;
        end while (!ready && n < 40);
        $display("[TB] op %s x=%0d mode=%0d -> result=%0d ovf=%0d (model %0d/%0d)",
                 tag, xi, mi, result, ovf, er, eo);
        check({tag, "_latency"}, n, TERMS + 2);
        check({tag, "_busy"}, busy_cnt, TERMS + 1);
        check({tag, "_result"}, result, er);
        check({tag, "_ovf"}, ovf, eo);
        @(negedge clk);
        check({tag, "_ready_pulse"}, ready, 0);
        check({tag, "_hold"}, result, er);
        last_res = er;
    endtask

    initial begin
        int n;
        int v;
        longint ra;
        longint rb;
        bit oa;
        bit ob;
        longint r05;
        logic signed [WIDTH-1:0] xa;
        logic signed [WIDTH-1:0] xb;
        logic signed [WIDTH-1:0] xr;

        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        x     = '0;

        // Reset asserted at 24 ns.
        #24 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_ovf", ovf, 0);
        check("rst_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ready", ready, 0);

        // tan(0.5), tanh(0.5), tan(-0.5)
        run_op("tan_p05", 16'sd8192, 1'b0);
        r05 = last_res;
        check("tan_p05_tol", ((result >= 8948) && (result <= 8952)) ? 1 : 0, 1);
        run_op("tanh_p05", 16'sd8192, 1'b1);
        check("tanh_p05_tol", ((result >= 7569) && (result <= 7573)) ? 1 : 0, 1);
        run_op("tan_m05", -16'sd8192, 1'b0);
        check("tan_m05_neg", result, -r05);

        // Saturation, then a clean zero.
        run_op("tan_1p99", 16'sd32604, 1'b0);
        check("tan_1p99_sat", result, 32767);
        check("tan_1p99_ovf", ovf, 1);
        run_op("tan_zero", 16'sd0, 1'b0);
        check("tan_zero_res", result, 0);
        check("tan_zero_ovf", ovf, 0);
        run_op("tan_min", -16'sd32768, 1'b0);
        run_op("tanh_max", 16'sd32767, 1'b1);

        // start held high across busy with x/mode churning; back-to-back from DONE.
        xa = 16'sd5000;
        xb = -16'sd12000;
        model(longint'(xa), 1'b0, ra, oa);
        model(longint'(xb), 1'b1, rb, ob);
        start = 1'b1;
        x     = xa;
        mode  = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ready) begin
                x    = WIDTH'($urandom);
                mode = 1'($urandom);
            end
        end while (!ready && n < 40);
        $display("[TB] op held x=%0d mode=0 -> result=%0d ovf=%0d (model %0d/%0d)", xa, result, ovf, ra, oa);
        check("held_latency", n, TERMS + 2);
        check("held_result", result, ra);
        check("held_ovf", ovf, oa);
        x    = xb;
        mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x     = '0;
        check("b2b_busy", busy, 1);
        check("b2b_ready", ready, 0);
        n = 1;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        $display("[TB] op b2b x=%0d mode=1 -> result=%0d ovf=%0d (model %0d/%0d)", xb, result, ovf, rb, ob);
        check("b2b_latency", n, TERMS + 2);
        check("b2b_result", result, rb);
        check("b2b_ovf", ovf, ob);
        @(negedge clk);

        // Asynchronous reset in the middle of HORNER.
        start = 1'b1;
        x     = 16'sd10000;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #5 rst = 1'b0;
        #1;
        $display("[TB] op midreset -> busy=%0d ready=%0d result=%0d ovf=%0d", busy, ready, result, ovf);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
        check("midrst_result", result, 0);
        check("midrst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_op("after_rst", 16'sd10000, 1'b0);

        // Randomised operands within the accurate range, then the full range.
        for (int i = 0; i < 16; i++) begin
            v  = int'($urandom_range(32768)) - 16384;
            xr = WIDTH'(v);
            run_op("rnd_in", xr, 1'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            xr = WIDTH'($urandom);
            run_op("rnd_full", xr, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
